seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Scan scheduler for the two 4-digit 7-segment displays (D0, D1) on the processor_arm board. It time-shares each display's segment bus across its four digits, one digit at a time. A 32-bit display word is written from the processor I/O path into a shadow register and committed only at a frame boundary, so the display never tears mid-scan. Sits between the processor's memory-mapped I/O write port and the board D0_seg/D1_seg/D0_a/D1_a pins.

Parameters:
DIV, 50000, clock cycles per digit slot; legal range DIV >= BLANK+2.
BLANK, 4, cycles at the start of each slot with all anodes off (anti-ghosting); BLANK >= 1.
LZB, 0, 1 enables leading-zero blanking per display.

Ports:
i_mclk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_wr_en  in  1  one-cycle write strobe for i_wr_data
i_wr_data  in  32  display word; [15:0] to D0, [31:16] to D1; nibble k shown on digit k
o_pending  out  1  shadow holds data not yet committed
o_commit  out  1  one-cycle pulse when shadow is copied to the display register
D0_seg  out  8  D0 segments, active-low {dp,g,f,e,d,c,b,a}
D1_seg  out  8  D1 segments, same encoding
D0_a  out  4  D0 anodes, active-low, bit k = digit k
D1_a  out  4  D1 anodes, same encoding

Behaviour:
- Reset (synchronous, i_reset=1 at an edge):
  - cnt=0, slot=0, shadow=0, disp=0, pending=0.
  - o_commit=0, D*_a=4'hF, D*_seg=8'hFF.
  - Applies mid-frame as well; the next frame starts at slot 0.
- Prescaler and slot counter:
  - cnt counts 0..DIV-1, then wraps to 0.
  - On the wrap, slot increments 0..3, then wraps to 0.
  - Frame period is 4*DIV cycles.
- Anode timing:
  - In slot k with cnt < BLANK: both anode buses are 4'hF and both seg buses are 8'hFF.
  - Otherwise: D0_a = D1_a = ~(1<<k).
- Segment data:
  - D0_seg = hex(disp[4k+3:4k]); D1_seg = hex(disp[16+4k+3:16+4k]).
  - dp is always off (bit7 = 1).
- Output registers: all seg/anode outputs are registered and lag (cnt, slot) by exactly one cycle. Both displays switch in the same cycle.
- Hex table: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Shadow write:
  - i_wr_en=1 loads shadow <= i_wr_data and sets pending=1 at that edge.
  - A later write in the same frame overwrites the shadow (last write wins).
- Commit (frame boundary cycle: slot=3 and cnt=DIV-1):
  - If pending=1 at the start of that cycle: disp <= shadow, pending <= 0, o_commit=1 for the following cycle only.
  - If pending=0: no commit and no pulse.
- Write in the boundary cycle:
  - The write loads the shadow and leaves pending=1.
  - The commit in that cycle (if any) uses the pre-write shadow.
  - The new data commits at the next boundary.
- Leading-zero blanking (LZB=1), applied per display:
  - Digit k (k>=1) is blanked when all of its nibbles k..3 are zero.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode high for the whole slot and its seg at 8'hFF.
- No backpressure: the block accepts a write every cycle.

Test Plan (DIV=8, BLANK=2):
1. Reset: i_reset=1 for 3 cycles, including one mid-frame -> D0_a=D1_a=4'hF, segs=8'hFF, o_pending=0, o_commit=0; first anode asserts exactly BLANK+1 cycles after reset release.
2. Write 0x1234ABCD once:
   - Next cycle o_pending=1; o_commit pulses once at the frame boundary.
   - Next frame D0_seg per slot 0..3 = A1, C6, 83, 88; D1_seg = 99, B0, A4, F9.
   - Each anode is low 6 cycles and high 2 cycles per slot.
3. Writes 0x11111111 then 0x22222222 within one frame -> single o_commit; all digits show A4.
4. Write 0x00000008 exactly in the boundary cycle -> no commit that boundary, o_pending stays 1; commit at the next boundary (32 cycles later); digit 0 of D0 shows 80.
5. LZB=1, write 0x00000005 -> D0: slot0 seg 92, slots1-3 anodes stay high. D1: slot0 seg C0, slots1-3 blanked.
6. i_reset pulse mid-scan after a commit -> disp cleared; after release with LZB=0, all digits show C0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Dual 4-digit 7-segment scan controller. A shadow word from the I/O write port
// is committed to the display register only at a frame boundary, so a scan never tears.
module seg_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 4,
  parameter bit LZB   = 1'b0
) (
  input  logic        i_mclk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  output logic        o_pending,
  output logic        o_commit,
  output logic [7:0]  D0_seg,
  output logic [7:0]  D1_seg,
  output logic [3:0]  D0_a,
  output logic [3:0]  D1_a
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   disp_q, disp_d;
  logic          pending_q, pending_d;
  logic          commit_q, commit_d;
  logic [7:0]    d0_seg_q, d0_seg_d, d1_seg_q, d1_seg_d;
  logic [3:0]    d0_a_q, d0_a_d, d1_a_q, d1_a_d;

  logic          wrap, boundary, blank, on0, on1;
  logic [3:0]    anode, nib0, nib1;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  // Digit k is lit unless leading-zero blanking finds nibbles k..3 all zero.
  function automatic logic digit_on(input logic [15:0] w, input logic [1:0] k);
    if (!LZB) begin
      digit_on = 1'b1;
    end else begin
      case (k)
        2'd0:    digit_on = 1'b1;
        2'd1:    digit_on = |w[15:4];
        2'd2:    digit_on = |w[15:8];
        default: digit_on = |w[15:12];
      endcase
    end
  endfunction

  always_comb begin
    wrap     = (cnt_q == CW'(DIV - 1));
    boundary = wrap && (slot_q == 2'd3);
    blank    = (cnt_q < CW'(BLANK));
    anode    = ~(4'b0001 << slot_q);
    nib0     = disp_q[{slot_q, 2'b00} +: 4];
    nib1     = disp_q[5'd16 + {1'b0, slot_q, 2'b00} +: 4];
    on0      = !blank && digit_on(disp_q[15:0], slot_q);
    on1      = !blank && digit_on(disp_q[31:16], slot_q);

    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    slot_d    = wrap ? slot_q + 2'd1 : slot_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    commit_d  = 1'b0;

    // Commit samples the pre-write shadow; a same-cycle write re-arms pending.
    if (boundary && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
      commit_d  = 1'b1;
    end
    if (i_wr_en) begin
      shadow_d  = i_wr_data;
      pending_d = 1'b1;
    end

    d0_a_d   = on0 ? anode : 4'hF;
    d1_a_d   = on1 ? anode : 4'hF;
    d0_seg_d = on0 ? hex7(nib0) : 8'hFF;
    d1_seg_d = on1 ? hex7(nib1) : 8'hFF;
  end

  always_ff @(posedge i_mclk) begin
    if (i_reset) begin
      cnt_q     <= '0;
      slot_q    <= 2'd0;
      shadow_q  <= 32'h0;
      disp_q    <= 32'h0;
      pending_q <= 1'b0;
      commit_q  <= 1'b0;
      d0_seg_q  <= 8'hFF;
      d1_seg_q  <= 8'hFF;
      d0_a_q    <= 4'hF;
      d1_a_q    <= 4'hF;
    end else begin
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      commit_q  <= commit_d;
      d0_seg_q  <= d0_seg_d;
      d1_seg_q  <= d1_seg_d;
      d0_a_q    <= d0_a_d;
      d1_a_q    <= d1_a_d;
    end
  end

  assign o_pending = pending_q;
  assign o_commit  = commit_q;
  assign D0_seg    = d0_seg_q;
  assign D1_seg    = d1_seg_q;
  assign D0_a      = d0_a_q;
  assign D1_a      = d1_a_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at DIV=8, BLANK=2; one instance without and one
// with leading-zero blanking share the same stimulus.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'h0;

  logic       pend0, com0, pend1, com1;
  logic [7:0] d0s0, d1s0, d0s1, d1s1;
  logic [3:0] d0a0, d1a0, d0a1, d1a1;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int commit_cnt = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(8), .BLANK(2), .LZB(1'b0)) u_dut0 (
    .i_mclk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_pending(pend0), .o_commit(com0),
    .D0_seg(d0s0), .D1_seg(d1s0), .D0_a(d0a0), .D1_a(d1a0)
  );

  seg_scan_ctrl #(.DIV(8), .BLANK(2), .LZB(1'b1)) u_dut1 (
    .i_mclk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_pending(pend1), .o_commit(com1),
    .D0_seg(d0s1), .D1_seg(d1s1), .D0_a(d0a1), .D1_a(d1a1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  // n = rising edges since the last reset edge; outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    if (com0) commit_cnt++;
  endtask

  task automatic write_word(input logic [31:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step();
      check_eq("rst_d0_a", 32'(d0a0), 32'hF);
      check_eq("rst_d1_a", 32'(d1a0), 32'hF);
      check_eq("rst_d0_seg", 32'(d0s0), 32'hFF);
      check_eq("rst_d1_seg", 32'(d1s0), 32'hFF);
      check_eq("rst_pending", 32'(pend0), 32'h0);
      check_eq("rst_commit", 32'(com0), 32'h0);
    end
    rst = 1'b0;
    n = 0;
  endtask

  // Checks 32 output cycles; byte k of e0/e1 is the seg value of slot k, v*_1 the lit digits of the LZB unit.
  task automatic check_frame(input logic [31:0] e0, input logic [31:0] e1,
                             input logic [3:0] v0_1, input logic [3:0] v1_1);
    int c, k;
    logic on;
    logic [3:0] an;
    for (int i = 0; i < 32; i++) begin
      step();
      c  = (n - 1) % 8;
      k  = ((n - 1) / 8) % 4;
      on = (c >= 2);
      an = 4'hF;
      an[k] = 1'b0;
      check_eq("d0_a", 32'(d0a0), on ? 32'(an) : 32'hF);
      check_eq("d1_a", 32'(d1a0), on ? 32'(an) : 32'hF);
      check_eq("d0_seg", 32'(d0s0), on ? 32'(e0[8*k +: 8]) : 32'hFF);
      check_eq("d1_seg", 32'(d1s0), on ? 32'(e1[8*k +: 8]) : 32'hFF);
      check_eq("lzb_d0_a", 32'(d0a1), (on && v0_1[k]) ? 32'(an) : 32'hF);
      check_eq("lzb_d1_a", 32'(d1a1), (on && v1_1[k]) ? 32'(an) : 32'hF);
      check_eq("lzb_d0_seg", 32'(d0s1), (on && v0_1[k]) ? 32'(e0[8*k +: 8]) : 32'hFF);
      check_eq("lzb_d1_seg", 32'(d1s1), (on && v1_1[k]) ? 32'(e1[8*k +: 8]) : 32'hFF);
    end
  endtask

  initial begin
    // 1: reset, then again mid-frame; first anode BLANK+1 edges after release.
    do_reset(2);
    run_to(13);
    do_reset(3);
    step();
    check_eq("first_blank1", 32'(d0a0), 32'hF);
    step();
    check_eq("first_blank2", 32'(d1a0), 32'hF);
    step();
    check_eq("first_anode_d0", 32'(d0a0), 32'hE);
    check_eq("first_anode_d1", 32'(d1a0), 32'hE);
    check_eq("first_seg_zero", 32'(d0s0), 32'hC0);

    // 2: single write, commit at first boundary, then a full frame.
    commit_cnt = 0;
    write_word(32'h1234ABCD);
    check_eq("wr_pending", 32'(pend0), 32'h1);
    check_eq("wr_no_commit", 32'(com0), 32'h0);
    run_to(31);
    check_eq("pre_boundary_commit", 32'(com0), 32'h0);
    step();
    check_eq("commit_pulse", 32'(com0), 32'h1);
    check_eq("commit_pulse_lzb", 32'(com1), 32'h1);
    check_eq("commit_clears_pending", 32'(pend0), 32'h0);
    check_frame(32'h88_83_C6_A1, 32'hF9_A4_B0_99, 4'hF, 4'hF);
    check_eq("commit_count_t2", 32'(commit_cnt), 32'd1);

    // 3: two writes in one frame, last wins, one commit.
    write_word(32'h11111111);
    run_to(70);
    write_word(32'h22222222);
    check_eq("t3_pending", 32'(pend0), 32'h1);
    run_to(96);
    check_eq("commit_count_t3", 32'(commit_cnt), 32'd2);
    check_frame(32'hA4A4A4A4, 32'hA4A4A4A4, 4'hF, 4'hF);
    check_eq("commit_count_t3_after", 32'(commit_cnt), 32'd2);

    // 4: write in the boundary cycle defers to the next boundary.
    run_to(159);
    write_word(32'h00000008);
    check_eq("t4_no_commit", 32'(com0), 32'h0);
    check_eq("t4_pending", 32'(pend0), 32'h1);
    check_frame(32'hA4A4A4A4, 32'hA4A4A4A4, 4'hF, 4'hF);
    check_eq("t4_commit_late", 32'(com0), 32'h1);
    check_eq("commit_count_t4", 32'(commit_cnt), 32'd3);
    check_eq("t4_pending_clear", 32'(pend0), 32'h0);
    check_frame(32'hC0C0C080, 32'hC0C0C0C0, 4'h1, 4'h1);

    // 5: leading-zero blanking on a single-digit value.
    write_word(32'h00000005);
    run_to(256);
    check_eq("commit_count_t5", 32'(commit_cnt), 32'd4);
    check_frame(32'hC0C0C092, 32'hC0C0C0C0, 4'h1, 4'h1);

    // 6: mid-scan reset clears the display register.
    run_to(301);
    do_reset(2);
    check_frame(32'hC0C0C0C0, 32'hC0C0C0C0, 4'h1, 4'h1);
    check_eq("t6_pending", 32'(pend0), 32'h0);
    check_eq("t6_commit_count", 32'(commit_cnt), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
